// File: rtl/servo_cmd_ctrl.sv
// Servo command sequencer: syncs SPI word strobe, clamps widths, applies at frame ticks.
// Optional slew limiting when SERVO_SLEW_LIMIT_EN is defined; default build jumps to target.
module servo_cmd_ctrl #(
  parameter int unsigned PW_MIN         = 1000,
  parameter int unsigned PW_MAX         = 2000,
  parameter int unsigned PW_CENTER      = 1500,
  parameter int unsigned SLEW_STEP      = 50,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        frame_tick,
  output logic [15:0] servo1_pw,
  output logic [15:0] servo2_pw,
  output logic        pw_update,
  output logic        cmd_accept,
  output logic        clamped,
  output logic        failsafe
);

  localparam logic [15:0] PwMin    = 16'(PW_MIN);
  localparam logic [15:0] PwMax    = 16'(PW_MAX);
  localparam logic [15:0] PwCenter = 16'(PW_CENTER);
  localparam int unsigned CntW     = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_FRAMES);

  if (SLEW_STEP == 0) begin : g_bad_slew
    $error("SLEW_STEP must be >= 1");
  end
  if (TIMEOUT_FRAMES == 0) begin : g_bad_timeout
    $error("TIMEOUT_FRAMES must be >= 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFailsafe} state_e;

  state_e          state;
  logic            s1, s2, s3;
  logic [15:0]     pend1, pend2;
  logic [CntW-1:0] cnt;

  logic            rx_edge;
  logic [15:0]     clamp1, clamp2;
  logic            out_of_range;
  logic [15:0]     target1, target2;
  logic [15:0]     next1, next2;

  function automatic logic [15:0] clamp_pw(input logic [15:0] v);
    if (v < PwMin) return PwMin;
    if (v > PwMax) return PwMax;
    return v;
  endfunction

`ifdef SERVO_SLEW_LIMIT_EN
  // Both operands lie in [PW_MIN, PW_MAX], so a bounded step toward target stays in range.
  function automatic logic [15:0] slew_pw(input logic [15:0] cur, input logic [15:0] tgt);
    logic signed [16:0] diff;
    logic signed [16:0] step;
    logic signed [16:0] sum;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > $signed(17'(SLEW_STEP))) begin
      step = $signed(17'(SLEW_STEP));
    end else if (diff < -$signed(17'(SLEW_STEP))) begin
      step = -$signed(17'(SLEW_STEP));
    end else begin
      step = diff;
    end
    sum = $signed({1'b0, cur}) + step;
    return sum[15:0];
  endfunction
`endif

  always_comb begin
    rx_edge      = s2 & ~s3;
    clamp1       = clamp_pw(rx_data[31:16]);
    clamp2       = clamp_pw(rx_data[15:0]);
    out_of_range = (rx_data[31:16] < PwMin) || (rx_data[31:16] > PwMax) ||
                   (rx_data[15:0] < PwMin)  || (rx_data[15:0] > PwMax);
    target1      = (state == StFailsafe) ? PwCenter : pend1;
    target2      = (state == StFailsafe) ? PwCenter : pend2;
`ifdef SERVO_SLEW_LIMIT_EN
    next1        = slew_pw(servo1_pw, target1);
    next2        = slew_pw(servo2_pw, target2);
`else
    next1        = target1;
    next2        = target2;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= StIdle;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      pend1      <= PwCenter;
      pend2      <= PwCenter;
      cnt        <= '0;
      servo1_pw  <= PwCenter;
      servo2_pw  <= PwCenter;
      pw_update  <= 1'b0;
      cmd_accept <= 1'b0;
      clamped    <= 1'b0;
      failsafe   <= 1'b0;
    end else begin
      s1         <= rx_valid;
      s2         <= s1;
      s3         <= s2;
      cmd_accept <= rx_edge;
      pw_update  <= 1'b0;

      // A tick in the same cycle still sees the old pend, since pend registers here too.
      if (rx_edge) begin
        pend1 <= clamp1;
        pend2 <= clamp2;
        if (out_of_range) clamped <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (rx_edge) begin
            state <= StRun;
            cnt   <= '0;
          end
        end
        StRun: begin
          if (frame_tick) begin
            servo1_pw <= next1;
            servo2_pw <= next2;
            pw_update <= 1'b1;
          end
          if (rx_edge) begin
            cnt <= '0;
          end else if (frame_tick) begin
            if (cnt != CntMax) cnt <= cnt + 1'b1;
            if (cnt + 1'b1 >= CntMax) begin
              state    <= StFailsafe;
              failsafe <= 1'b1;
            end
          end
        end
        StFailsafe: begin
          if (frame_tick) begin
            servo1_pw <= next1;
            servo2_pw <= next2;
            pw_update <= 1'b1;
          end
          if (rx_edge) begin
            state    <= StRun;
            failsafe <= 1'b0;
            cnt      <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
